// File: rtl/store_align.sv
// Store-path alignment and data-memory bus sequencer: positions store data into
// byte lanes, builds strobes, and issues one or two word beats over req/gnt.
module store_align #(
  parameter int REG_WIDTH_IN_BYTE = 4,
  parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [31:0]                  st_addr,
  input  logic [REG_WIDTH_IN_BIT-1:0]  st_data,
  input  logic [2:0]                   st_funct3,
  output logic                         mem_req,
  input  logic                         mem_gnt,
  output logic [31:0]                  mem_addr,
  output logic [REG_WIDTH_IN_BIT-1:0]  mem_wdata,
  output logic [REG_WIDTH_IN_BYTE-1:0] mem_wstrb,
  output logic                         st_done,
  output logic                         st_err,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  localparam int W = REG_WIDTH_IN_BIT;
  localparam int B = REG_WIDTH_IN_BYTE;

  // Handshakes: a store is taken when st_valid && st_ready in the same cycle;
  // a bus beat completes when mem_req && mem_gnt. mem_req, once raised, stays
  // high with a stable payload until granted.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]    addr_q;
  logic [W-1:0]   wdata_q;
  logic [W-1:0]   hi_data_q;
  logic [2*B-1:0] mask_q;

  logic           accept;
  logic           legal;
  logic           beat_hs;
  logic [1:0]     off;
  logic [B-1:0]   base;
  logic [2*W-1:0] wide_in;
  logic [2*B-1:0] mask_in;

  assign off     = st_addr[1:0];
  assign accept  = st_valid && st_ready;
  assign beat_hs = mem_req && mem_gnt;

  always_comb begin
    legal = 1'b1;
    base  = '0;
    case (st_funct3)
      3'b000:  base = 4'b0001;
      3'b001:  base = 4'b0011;
      3'b010:  base = 4'b1111;
      default: legal = 1'b0;
    endcase
  end

  assign wide_in = {{W{1'b0}}, st_data} << {off, 3'b000};
  assign mask_in = {{B{1'b0}}, base} << off;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = legal ? S_BEAT0 : S_ERR;
      S_BEAT0: if (beat_hs) state_d = (mask_q[2*B-1:B] != '0) ? S_BEAT1 : S_DONE;
      S_BEAT1: if (beat_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      hi_data_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept && legal) begin
        addr_q    <= {st_addr[31:2], 2'b00};
        wdata_q   <= wide_in[W-1:0];
        hi_data_q <= wide_in[2*W-1:W];
        mask_q    <= mask_in;
      end else if (state_q == S_BEAT0 && beat_hs && mask_q[2*B-1:B] != '0) begin
        // Second beat: next word, wrapping at the top of the address space.
        addr_q  <= addr_q + 32'd4;
        wdata_q <= hi_data_q;
      end
    end
  end

  assign st_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (state_q == S_BEAT0) ? mask_q[B-1:0] :
                     (state_q == S_BEAT1) ? mask_q[2*B-1:B] : '0;
  assign st_done   = (state_q == S_DONE);
  assign st_err    = (state_q == S_ERR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: expected beats and completion events are
// queued by the driver and consumed by an independent negedge monitor.
module tb_store_align;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        st_done;
  logic        st_err;
  logic        busy;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int errors  = 0;

  logic [67:0] exp_q[$];
  logic [1:0]  ev_q[$];

  logic        prev_stall;
  logic [67:0] prev_payload;
  logic [67:0] mon_exp;
  logic [1:0]  mon_ev;

  store_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .st_done   (st_done),
    .st_err    (st_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({a, d, s});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_req && mem_gnt) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {mem_addr, mem_wdata, mem_wstrb}, 68'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", {mem_addr, mem_wdata, mem_wstrb}, mon_exp);
        end
      end
      if (!mem_req) check("idle_strb", mem_wstrb, 4'b0000);
      if (prev_stall) check("stall_hold", {mem_req, mem_addr, mem_wdata, mem_wstrb},
                            {1'b1, prev_payload});
      if (st_done || st_err) begin
        if (ev_q.size() == 0) begin
          check("unexpected_event", {st_done, st_err}, 2'b00);
        end else begin
          mon_ev = ev_q.pop_front();
          check("event", {st_err, st_done}, mon_ev);
        end
      end
      prev_stall   = mem_req && !mem_gnt;
      prev_payload = {mem_addr, mem_wdata, mem_wstrb};
    end
  end

  // driver: ev 1 = st_done expected, 2 = st_err expected
  task automatic run_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] f3, input int stall, input logic [1:0] ev,
                           input int exp_lat, input int exp_req);
    int lat;
    int req_cycles;
    lat = 0;
    req_cycles = 0;
    for (int i = 0; i < 20 && !st_ready; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_ready_in"}, st_ready, 1'b1);
    ev_q.push_back(ev);
    mem_gnt   = (stall == 0);
    st_addr   = addr;
    st_data   = data;
    st_funct3 = f3;
    st_valid  = 1'b1;
    @(posedge clk); #1;
    st_valid  = 1'b0;
    st_addr   = $urandom_range(0, 32'hFFFF);
    st_data   = $urandom_range(0, 32'hFFFF);
    st_funct3 = 3'($urandom_range(0, 7));
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (st_done || st_err) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
      if (k == stall) mem_gnt = 1'b1;
    end
    mem_gnt = 1'b1;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_req_cycles"}, req_cycles, exp_req);
    @(posedge clk); #1;
    check({name, "_ready_after"}, {st_ready, busy}, 2'b10);
  endtask

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_funct3 = '0;
    mem_gnt   = 1'b1;
    #12;
    check("reset_outputs",
          {st_ready, busy, mem_req, mem_wstrb, mem_addr, mem_wdata, st_done, st_err},
          {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_beat(32'h0000_1000, 32'hA500_0000, 4'b1000);
    run_store("sb_off3", 32'h0000_1003, 32'h0000_00A5, 3'b000, 0, 2'd1, 2, 1);

    expect_beat(32'h0000_2000, 32'h3344_0000, 4'b1100);
    expect_beat(32'h0000_2004, 32'h0000_1122, 4'b0011);
    run_store("sw_split", 32'h0000_2002, 32'h1122_3344, 3'b010, 0, 2'd1, 3, 2);

    expect_beat(32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
    expect_beat(32'h0000_0000, 32'h0000_00BE, 4'b0001);
    run_store("sh_wrap", 32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 0, 2'd1, 3, 2);

    expect_beat(32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);
    run_store("sw_stall", 32'h0000_0040, 32'hDEAD_BEEF, 3'b010, 3, 2'd1, 5, 4);

    expect_beat(32'h0000_1000, 32'hCAFE_0000, 4'b1100);
    run_store("sh_off2", 32'h0000_1002, 32'h0000_CAFE, 3'b001, 0, 2'd1, 2, 1);

    expect_beat(32'h0000_2000, 32'h0000_005A, 4'b0001);
    run_store("sb_off0", 32'h0000_2000, 32'h0000_005A, 3'b000, 0, 2'd1, 2, 1);

    run_store("ill_011", 32'h0000_0100, 32'h1234_5678, 3'b011, 0, 2'd2, 1, 0);
    run_store("ill_111", 32'h0000_0104, 32'h8765_4321, 3'b111, 0, 2'd2, 1, 0);

    expect_beat(32'h0000_3000, 32'h4400_0000, 4'b1000);
    expect_beat(32'h0000_3004, 32'h0011_2233, 4'b0111);
    run_store("sw_off3_stall", 32'h0000_3003, 32'h1122_3344, 3'b010, 2, 2'd1, 5, 4);

    // Reset while the second beat waits for grant.
    expect_beat(32'h0000_3000, 32'hBBCC_DD00, 4'b1110);
    mem_gnt   = 1'b1;
    st_addr   = 32'h0000_3001;
    st_data   = 32'hAABB_CCDD;
    st_funct3 = 3'b010;
    st_valid  = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rst_beat1_wait", {mem_req, mem_addr, mem_wdata, mem_wstrb},
          {1'b1, 32'h0000_3004, 32'h0000_00AA, 4'b0001});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop",
          {st_ready, busy, mem_req, mem_wstrb, mem_addr, mem_wdata, st_done, st_err},
          {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0});
    @(posedge clk); @(posedge clk); #1;
    rst_n   = 1'b1;
    mem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_release",
          {st_ready, busy, mem_req, mem_wstrb, mem_addr, mem_wdata, st_done, st_err},
          {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0});

    expect_beat(32'h0000_0050, 32'h0102_0304, 4'b1111);
    run_store("sw_after_rst", 32'h0000_0050, 32'h0102_0304, 3'b010, 0, 2'd1, 2, 1);

    repeat (3) @(posedge clk);
    #1;
    check("beat_q_empty", exp_q.size(), 0);
    check("event_q_empty", ev_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/store_align.md
# store_align

Store-path alignment and bus sequencer for the MEM stage; the write-side counterpart of the load extension logic. Accepts one store per handshake (address, data, funct3), shifts the data into byte lanes and builds the byte strobes. Issues the result to the data-memory bus with a req/gnt handshake. Stores that cross a 32-bit word boundary are split into two bus beats.

## Interface
- REG_WIDTH_IN_BYTE, 4, data/bus width in bytes; only 4 is supported.
- REG_WIDTH_IN_BIT, REG_WIDTH_IN_BYTE*8, data/bus width in bits.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- st_valid  in  1  store request valid.
- st_ready  out  1  block can accept a request; high only in IDLE.
- st_addr  in  32  byte address of the store.
- st_data  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- st_funct3  in  3  000 SB, 001 SH, 010 SW; any other value is illegal.
- mem_req  out  1  bus beat request.
- mem_gnt  in  1  bus accepts the beat in the cycle where mem_req && mem_gnt.
- mem_addr  out  32  word-aligned beat address; bits [1:0] are always 00.
- mem_wdata  out  32  lane-positioned write data.
- mem_wstrb  out  4  byte-lane write enables.
- st_done  out  1  one-cycle pulse: the whole store has completed.
- st_err  out  1  one-cycle pulse: illegal funct3 was accepted and dropped.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE → BEAT0 on accept, when st_valid && st_ready and funct3 is legal.
  - IDLE → ERR on accept with illegal funct3.
  - BEAT0 → BEAT1 on handshake when the high strobe half is non-zero.
  - BEAT0 → DONE on handshake when the high strobe half is zero.
  - BEAT1 → DONE on handshake.
  - DONE → IDLE; ERR → IDLE (unconditional, 1 cycle each).
- On accept, capture off = st_addr[1:0], the word address {st_addr[31:2],2'b00}, and the following:
  - wide = {32'b0, st_data} << (off*8), 64 bits.
  - mask = base << off, 8 bits; base = 0001 for SB, 0011 for SH, 1111 for SW.
- BEAT0 drives:
  - mem_addr = the word address.
  - mem_wdata = wide[31:0].
  - mem_wstrb = mask[3:0].
- BEAT1 drives:
  - mem_addr = word address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - mem_wdata = wide[63:32].
  - mem_wstrb = mask[7:4].
- Splits occur for SH at off=3 and for SW at off≠0; SB never splits.
- mem_req is high throughout BEAT0 and BEAT1.
- While mem_req && !mem_gnt, mem_addr, mem_wdata and mem_wstrb are held stable.
- mem_req is never withdrawn before it is granted.
- Outside BEAT states, mem_req = 0 and mem_wstrb = 0. mem_addr and mem_wdata hold their last value.
- st_done is high in DONE only; st_err is high in ERR only.
- Illegal funct3 produces no bus activity.
- Input changes while busy are ignored; no request is captured outside IDLE.

## Timing
- Reset values:
  - State = IDLE, so st_ready = 1 and busy = 0.
  - mem_req = 0, mem_wstrb = 0, mem_addr = 0, mem_wdata = 0.
  - st_done = 0, st_err = 0.
- Reset asserted mid-operation abandons the store immediately: mem_req drops asynchronously and no st_done is produced.
- Accept in cycle T gives mem_req = 1 from T+1.
- Single beat with immediate grant: handshake at T+1, st_done at T+2, st_ready = 1 at T+3.
- Split store with immediate grants: beats at T+1 and T+2, st_done at T+3.
- Each cycle of mem_gnt = 0 stretches the current beat by one cycle.
- Illegal funct3: st_err at T+1, st_ready = 1 at T+2.
- Peak throughput: one aligned store every 3 cycles.

## Test plan
- SB, addr 0x1003, data 0xA5, gnt tied 1:
  - one beat: addr 0x1000, wdata 0xA5000000, wstrb 1000.
  - st_done 2 cycles after accept.
- SW, addr 0x2002, data 0x11223344, gnt tied 1:
  - beat0: addr 0x2000, wdata 0x33440000, wstrb 1100.
  - beat1: addr 0x2004, wdata 0x00001122, wstrb 0011.
  - st_done at T+3.
- SH, addr 0xFFFFFFFF, data 0xBEEF:
  - beat0: addr 0xFFFFFFFC, wstrb 1000, wdata 0xEF000000.
  - beat1: addr 0x00000000, wstrb 0001, wdata 0x000000BE.
- SW aligned, addr 0x40, with gnt held low for 3 cycles:
  - mem_req and the payload are stable for 4 cycles.
  - exactly one handshake, then st_done.
- funct3 = 011 accepted:
  - no mem_req.
  - st_err pulse at T+1, st_ready back high at T+2.
- Reset pulse while BEAT1 waits for gnt:
  - mem_req falls immediately, with no st_done.
  - after release: st_ready = 1, all outputs at reset values.
